// File: rtl/sdram_pattern_tester.sv
// Avalon-MM traffic generator/checker for the SDRAM controller az_/za_ port:
// writes a pattern over [START_ADDR, END_ADDR], reads it back pipelined and compares.
module sdram_pattern_tester #(
  parameter int unsigned       ADDR_W          = 22,
  parameter int unsigned       DATA_W          = 16,
  parameter int unsigned       BE_W            = DATA_W / 8,
  parameter int unsigned       MAX_OUTSTANDING = 4,
  parameter logic [ADDR_W-1:0] START_ADDR      = '0,
  parameter logic [ADDR_W-1:0] END_ADDR        = '1,
  parameter logic [31:0]       LFSR_SEED       = 32'hACE1_2468
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] az_addr,
  output logic [BE_W-1:0]   az_be_n,
  output logic [DATA_W-1:0] az_data,
  output logic              az_rd_n,
  output logic              az_wr_n,
  input  logic [DATA_W-1:0] za_data,
  input  logic              za_valid,
  input  logic              za_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              aborted,
  output logic [15:0]       err_count,
  output logic [15:0]       pass_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam int unsigned PW      = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned LW      = (DATA_W > 32) ? DATA_W : 32;
  localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [31:0] s);
    logic [PW-1:0]     ext;
    logic [LW-1:0]     sx;
    logic [ADDR_W-1:0] bitpos;
    logic [DATA_W-1:0] w;
    ext    = PW'(a);
    sx     = LW'(s);
    bitpos = a % ADDR_W'(DATA_W);
    case (m)
      2'd0:    w = ext[DATA_W-1:0];
      2'd1:    w = ~ext[DATA_W-1:0];
      2'd2:    w = DATA_W'(1) << bitpos;
      default: w = sx[DATA_W-1:0];
    endcase
    return w;
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d, chk_addr_q, chk_addr_d;
  logic [31:0]       wr_lfsr_q, wr_lfsr_d, chk_lfsr_q, chk_lfsr_d;
  logic [3:0]        out_q, out_d;
  logic [DATA_W-1:0] az_data_q, az_data_d;
  logic              az_rd_n_q, az_rd_n_d, az_wr_n_q, az_wr_n_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic              aborted_q, aborted_d, err_seen_q, err_seen_d;
  logic [15:0]       err_count_q, err_count_d, pass_count_q, pass_count_d;
  logic [ADDR_W-1:0] fe_addr_q, fe_addr_d;
  logic [DATA_W-1:0] fe_exp_q, fe_exp_d, fe_got_q, fe_got_d;

  logic              wr_acc, rd_acc, real_valid, launch;
  logic [ADDR_W-1:0] addr_inc;
  logic [31:0]       wr_lfsr_inc;
  logic [DATA_W-1:0] exp_word;

  always_comb begin
    wr_acc      = !az_wr_n_q && !za_waitrequest;
    rd_acc      = !az_rd_n_q && !za_waitrequest;
    real_valid  = za_valid && (out_q != 4'd0);
    addr_inc    = addr_q + ADDR_W'(1);
    wr_lfsr_inc = lfsr_next(wr_lfsr_q);
    exp_word    = pattern(mode_q, chk_addr_q, chk_lfsr_q);
    launch      = 1'b0;

    state_d      = state_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    chk_addr_d   = chk_addr_q;
    wr_lfsr_d    = wr_lfsr_q;
    chk_lfsr_d   = chk_lfsr_q;
    out_d        = out_q + 4'(rd_acc) - 4'(real_valid);
    az_data_d    = az_data_q;
    az_rd_n_d    = az_rd_n_q;
    az_wr_n_d    = az_wr_n_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    aborted_d    = aborted_q;
    err_seen_d   = err_seen_q;
    err_count_d  = err_count_q;
    pass_count_d = pass_count_q;
    fe_addr_d    = fe_addr_q;
    fe_exp_d     = fe_exp_q;
    fe_got_d     = fe_got_q;

    // Checker runs in every state so stray read data is counted even when idle.
    if (za_valid) begin
      if (!real_valid) begin
        err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
      end else begin
        chk_addr_d = chk_addr_q + ADDR_W'(1);
        chk_lfsr_d = lfsr_next(chk_lfsr_q);
        if (za_data != exp_word) begin
          err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
          if (!err_seen_q) begin
            err_seen_d = 1'b1;
            fe_addr_d  = chk_addr_q;
            fe_exp_d   = exp_word;
            fe_got_d   = za_data;
          end
        end
      end
    end

    case (state_q)
      S_IDLE: if (start) launch = 1'b1;
      S_WRITE: begin
        if (abort) begin
          state_d   = S_DONE;
          az_wr_n_d = 1'b1;
          aborted_d = 1'b1;
          pass_d    = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else if (wr_acc) begin
          if (addr_q == END_ADDR) begin
            state_d   = S_READ;
            az_wr_n_d = 1'b1;
            addr_d    = START_ADDR;
            az_rd_n_d = !(out_d < MAX_OUT);
          end else begin
            addr_d    = addr_inc;
            wr_lfsr_d = wr_lfsr_inc;
            az_data_d = pattern(mode_q, addr_inc, wr_lfsr_inc);
          end
        end
      end
      S_READ: begin
        if (abort) begin
          state_d   = S_DRAIN;
          az_rd_n_d = 1'b1;
          aborted_d = 1'b1;
        end else begin
          if (rd_acc) begin
            if (addr_q == END_ADDR) state_d = S_DRAIN;
            else addr_d = addr_inc;
          end
          // A stalled read can only see out_d <= out_q < MAX_OUT, so it stays asserted.
          az_rd_n_d = (state_d != S_READ) || !(out_d < MAX_OUT);
        end
      end
      S_DRAIN: begin
        if (out_q == 4'd0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_count_q == 16'd0) && !aborted_q;
        end
      end
      S_DONE: begin
        if (loop_en && pass_q && !aborted_q) begin
          pass_count_d = pass_count_q + 16'd1;
          launch       = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d     = S_WRITE;
      mode_d      = mode;
      addr_d      = START_ADDR;
      chk_addr_d  = START_ADDR;
      wr_lfsr_d   = LFSR_SEED;
      chk_lfsr_d  = LFSR_SEED;
      az_data_d   = pattern(mode, START_ADDR, LFSR_SEED);
      az_wr_n_d   = 1'b0;
      az_rd_n_d   = 1'b1;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      aborted_d   = 1'b0;
      err_seen_d  = 1'b0;
      err_count_d = '0;
      fe_addr_d   = '0;
      fe_exp_d    = '0;
      fe_got_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      addr_q       <= '0;
      chk_addr_q   <= '0;
      wr_lfsr_q    <= '0;
      chk_lfsr_q   <= '0;
      out_q        <= '0;
      az_data_q    <= '0;
      az_rd_n_q    <= 1'b1;
      az_wr_n_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      aborted_q    <= 1'b0;
      err_seen_q   <= 1'b0;
      err_count_q  <= '0;
      pass_count_q <= '0;
      fe_addr_q    <= '0;
      fe_exp_q     <= '0;
      fe_got_q     <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      chk_addr_q   <= chk_addr_d;
      wr_lfsr_q    <= wr_lfsr_d;
      chk_lfsr_q   <= chk_lfsr_d;
      out_q        <= out_d;
      az_data_q    <= az_data_d;
      az_rd_n_q    <= az_rd_n_d;
      az_wr_n_q    <= az_wr_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      aborted_q    <= aborted_d;
      err_seen_q   <= err_seen_d;
      err_count_q  <= err_count_d;
      pass_count_q <= pass_count_d;
      fe_addr_q    <= fe_addr_d;
      fe_exp_q     <= fe_exp_d;
      fe_got_q     <= fe_got_d;
    end
  end

  assign az_addr        = addr_q;
  assign az_be_n        = '0;
  assign az_data        = az_data_q;
  assign az_rd_n        = az_rd_n_q;
  assign az_wr_n        = az_wr_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign aborted        = aborted_q;
  assign err_count      = err_count_q;
  assign pass_count     = pass_count_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_exp  = fe_exp_q;
  assign first_err_got  = fe_got_q;

endmodule
